// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of a single-outstanding memory port.
//
// Picks one requester at a time (fixed priority or round-robin), registers
// its command and holds it on the mem_* outputs until mem_resp, then
// pulses that port's req_resp. Between transactions the block always spends
// one IDLE cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_read/write    per-port request strobes (NUM_PORTS bits)
//   req_addr/wdata/mbe per-port packed command fields, port i at [i*W +: W]
//   req_resp          per-port one-cycle completion pulse
//   req_rdata         read data, broadcast (mirrors mem_rdata)
//   mem_*             downstream command/response interface
//
// States:
//   IDLE | no transaction outstanding; grant sampled at next edge
//   BUSY | one command held on mem_*, waiting for mem_resp
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MODE      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_mbe,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [DATA_W-1:0]               req_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_mbe,
  input  logic                            mem_resp,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int MBE_W = DATA_W / 8;
  localparam int GW    = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        last_grant_q;
  logic [GW-1:0]        pick;
  logic                 pick_valid;
  logic [NUM_PORTS-1:0] req_any;

  assign req_rdata = mem_rdata;

  // Grant selection. Loops run from lowest to highest priority so the last
  // match written is the winner.
  always_comb begin
    int idx;
    idx        = 0;
    req_any    = req_read | req_write;
    pick       = '0;
    pick_valid = 1'b0;
    if (MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_any[i]) begin
          pick       = GW'(i);
          pick_valid = 1'b1;
        end
      end
    end else begin
      // k = NUM_PORTS lands on last_grant itself: lowest priority.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = (int'(last_grant_q) + k) % NUM_PORTS;
        if (req_any[idx]) begin
          pick       = GW'(idx);
          pick_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_resp = '0;
    case (state_q)
      IDLE: if (pick_valid) state_d = BUSY;
      BUSY: begin
        if (mem_resp) begin
          state_d = IDLE;
          if (!rst) req_resp[grant_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_mbe      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            // write wins when a port raises both strobes
            mem_write    <= req_write[pick];
            mem_read     <= req_read[pick] & ~req_write[pick];
            mem_addr     <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
            mem_wdata    <= req_wdata[int'(pick)*DATA_W +: DATA_W];
            mem_mbe      <= req_mbe[int'(pick)*MBE_W +: MBE_W];
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// dut0: 2 ports, fixed priority. dut1: 4 ports, round-robin.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- dut0: NUM_PORTS=2, MODE=0 ----------------
  logic [1:0]  d0_rd, d0_wr, d0_resp;
  logic [31:0] d0_a [2];
  logic [31:0] d0_w [2];
  logic [3:0]  d0_m [2];
  logic [63:0] d0_addr, d0_wdata;
  logic [7:0]  d0_mbe;
  logic [31:0] d0_rdata, d0_maddr, d0_mwdata, d0_mrdata;
  logic        d0_mread, d0_mwrite, d0_mresp;
  logic [3:0]  d0_mmbe;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      d0_addr[i*32 +: 32]  = d0_a[i];
      d0_wdata[i*32 +: 32] = d0_w[i];
      d0_mbe[i*4 +: 4]     = d0_m[i];
    end
  end

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_read(d0_rd), .req_write(d0_wr), .req_addr(d0_addr),
    .req_wdata(d0_wdata), .req_mbe(d0_mbe), .req_resp(d0_resp),
    .req_rdata(d0_rdata), .mem_read(d0_mread), .mem_write(d0_mwrite),
    .mem_addr(d0_maddr), .mem_wdata(d0_mwdata), .mem_mbe(d0_mmbe),
    .mem_resp(d0_mresp), .mem_rdata(d0_mrdata)
  );

  // ---------------- dut1: NUM_PORTS=4, MODE=1 ----------------
  logic [3:0]   d1_rd, d1_wr, d1_resp;
  logic [127:0] d1_addr, d1_wdata;
  logic [15:0]  d1_mbe;
  logic [31:0]  d1_rdata, d1_maddr, d1_mwdata, d1_mrdata;
  logic         d1_mread, d1_mwrite, d1_mresp;
  logic [3:0]   d1_mmbe;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      d1_addr[i*32 +: 32]  = 32'h1000 + 32'(i * 16);
      d1_wdata[i*32 +: 32] = 32'h0;
      d1_mbe[i*4 +: 4]     = 4'hF;
    end
  end

  mem_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_read(d1_rd), .req_write(d1_wr), .req_addr(d1_addr),
    .req_wdata(d1_wdata), .req_mbe(d1_mbe), .req_resp(d1_resp),
    .req_rdata(d1_rdata), .mem_read(d1_mread), .mem_write(d1_mwrite),
    .mem_addr(d1_maddr), .mem_wdata(d1_mwdata), .mem_mbe(d1_mmbe),
    .mem_resp(d1_mresp), .mem_rdata(d1_mrdata)
  );

  // ---------------- checking helpers ----------------
  typedef struct {
    int          port;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } exp_t;

  exp_t sb[$];
  int   rr_q[$];

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0]  m0, m1;
    int          lat;
    logic [31:0] rdata;
    int          port;
    logic        xrd;
    logic        xwr;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    int         port;
  } rr_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem0(input string tag, input exp_t e);
    chk({tag, ".mem_read"},  32'(d0_mread),  32'(e.rd));
    chk({tag, ".mem_write"}, 32'(d0_mwrite), 32'(e.wr));
    chk({tag, ".mem_addr"},  d0_maddr,       e.addr);
    chk({tag, ".mem_wdata"}, d0_mwdata,      e.wdata);
    chk({tag, ".mem_mbe"},   32'(d0_mmbe),   32'(e.mbe));
  endtask

  task automatic sb_pop_check(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.sb_empty: got no expected entry, expected one", tag);
      e = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    end else begin
      e = sb.pop_front();
      chk_mem0(tag, e);
    end
  endtask

  task automatic d0_idle_inputs();
    d0_rd = '0;
    d0_wr = '0;
    for (int i = 0; i < 2; i++) begin
      d0_a[i] = '0;
      d0_w[i] = '0;
      d0_m[i] = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    rr_t  rr[11];
    exp_t e;
    logic [31:0] rd_v;
    logic [3:0]  one;
    int          p;

    vt[0] = '{2'b10, 2'b00, 32'h0,    32'h1000, 32'h0,        32'hCAFE0001, 4'h0, 4'hF, 3, 32'hDEADBEEF, 1, 1'b1, 1'b0};
    vt[1] = '{2'b00, 2'b01, 32'h40,   32'h0,    32'h11223344, 32'h0,        4'h3, 4'h0, 4, 32'h0,        0, 1'b0, 1'b1};
    vt[2] = '{2'b01, 2'b01, 32'h80,   32'h0,    32'hA5A5A5A5, 32'h0,        4'hF, 4'h0, 2, 32'h12345678, 0, 1'b0, 1'b1};
    vt[3] = '{2'b11, 2'b00, 32'h100,  32'h200,  32'h1,        32'h2,        4'h1, 4'h2, 1, 32'h0BADF00D, 0, 1'b1, 1'b0};
    vt[4] = '{2'b00, 2'b10, 32'h0,    32'h300,  32'h0,        32'h55667788, 4'h0, 4'hC, 2, 32'h0,        1, 1'b0, 1'b1};
    vt[5] = '{2'b10, 2'b01, 32'h500,  32'h600,  32'h99,       32'h88,       4'h5, 4'hA, 1, 32'hFFFF0000, 0, 1'b0, 1'b1};

    rr[0]  = '{4'b1111, 0};
    rr[1]  = '{4'b1111, 1};
    rr[2]  = '{4'b1111, 2};
    rr[3]  = '{4'b1111, 3};
    rr[4]  = '{4'b1111, 0};
    rr[5]  = '{4'b0101, 2};
    rr[6]  = '{4'b0101, 0};
    rr[7]  = '{4'b1001, 3};
    rr[8]  = '{4'b0110, 1};
    rr[9]  = '{4'b0011, 0};
    rr[10] = '{4'b0010, 1};

    rst = 1'b1;
    d0_idle_inputs();
    d0_mresp = 1'b0; d0_mrdata = '0;
    d1_rd = '0; d1_wr = '0; d1_mresp = 1'b0; d1_mrdata = '0;
    repeat (3) step();

    chk("reset.mem_read",  32'(d0_mread),  32'h0);
    chk("reset.mem_write", 32'(d0_mwrite), 32'h0);
    chk("reset.mem_addr",  d0_maddr,       32'h0);
    chk("reset.mem_wdata", d0_mwdata,      32'h0);
    chk("reset.mem_mbe",   32'(d0_mmbe),   32'h0);
    chk("reset.req_resp",  32'(d0_resp),   32'h0);
    chk("reset.rr_mem_read", 32'(d1_mread), 32'h0);
    rst = 1'b0;
    step();

    // table-driven single transactions on dut0
    for (int v = 0; v < 6; v++) begin
      d0_rd = vt[v].rd;   d0_wr = vt[v].wr;
      d0_a[0] = vt[v].a0; d0_a[1] = vt[v].a1;
      d0_w[0] = vt[v].w0; d0_w[1] = vt[v].w1;
      d0_m[0] = vt[v].m0; d0_m[1] = vt[v].m1;
      sb.push_back('{vt[v].port, vt[v].xrd, vt[v].xwr,
                     vt[v].port == 1 ? vt[v].a1 : vt[v].a0,
                     vt[v].port == 1 ? vt[v].w1 : vt[v].w0,
                     vt[v].port == 1 ? vt[v].m1 : vt[v].m0});
      step();
      sb_pop_check($sformatf("vec%0d.grant", v), e);
      for (int c = 1; c < vt[v].lat; c++) begin
        d0_rd = 2'($urandom); d0_wr = 2'($urandom);
        d0_a[0] = $urandom; d0_a[1] = $urandom;
        d0_w[0] = $urandom; d0_w[1] = $urandom;
        d0_m[0] = 4'($urandom); d0_m[1] = 4'($urandom);
        step();
        chk_mem0($sformatf("vec%0d.hold%0d", v, c), e);
      end
      d0_mresp = 1'b1;
      d0_mrdata = vt[v].rdata;
      #1;
      one = 4'b0001 << e.port;
      chk($sformatf("vec%0d.req_resp", v),  32'(d0_resp), 32'(one[1:0]));
      chk($sformatf("vec%0d.req_rdata", v), d0_rdata,     vt[v].rdata);
      step();
      d0_mresp = 1'b0;
      d0_idle_inputs();
      #1;
      chk($sformatf("vec%0d.resp_once", v), 32'(d0_resp),   32'h0);
      chk($sformatf("vec%0d.rd_clear", v),  32'(d0_mread),  32'h0);
      chk($sformatf("vec%0d.wr_clear", v),  32'(d0_mwrite), 32'h0);
    end

    // fixed-priority contention: port0 first, port1 after one IDLE gap
    d0_rd = 2'b11;
    d0_a[0] = 32'h100; d0_a[1] = 32'h200;
    d0_w[0] = 32'h10;  d0_w[1] = 32'h20;
    d0_m[0] = 4'hF;    d0_m[1] = 4'hF;
    sb.push_back('{0, 1'b1, 1'b0, 32'h100, 32'h10, 4'hF});
    sb.push_back('{1, 1'b1, 1'b0, 32'h200, 32'h20, 4'hF});
    step();
    sb_pop_check("contend.first", e);
    d0_mresp = 1'b1; d0_mrdata = 32'h1111;
    #1;
    chk("contend.resp0", 32'(d0_resp), 32'h1);
    step();
    d0_mresp = 1'b0;
    d0_rd = 2'b10;
    #1;
    chk("contend.gap_rd", 32'(d0_mread), 32'h0);
    chk("contend.gap_resp", 32'(d0_resp), 32'h0);
    step();
    sb_pop_check("contend.second", e);
    d0_mresp = 1'b1; d0_mrdata = 32'h2222;
    #1;
    chk("contend.resp1", 32'(d0_resp), 32'h2);
    chk("contend.rdata", d0_rdata, 32'h2222);
    step();
    d0_mresp = 1'b0;
    d0_idle_inputs();

    // mem_resp in IDLE is ignored
    d0_mresp = 1'b1;
    #1;
    chk("idle_resp.req_resp", 32'(d0_resp), 32'h0);
    step();
    d0_mresp = 1'b0;
    chk("idle_resp.mem_read",  32'(d0_mread),  32'h0);
    chk("idle_resp.mem_write", 32'(d0_mwrite), 32'h0);
    step();

    // reset during BUSY, late mem_resp
    d0_rd = 2'b10; d0_a[1] = 32'h700;
    step();
    chk("rstmid.busy_rd", 32'(d0_mread), 32'h1);
    step();
    rst = 1'b1;
    d0_mresp = 1'b1;
    #1;
    chk("rstmid.resp_gated", 32'(d0_resp), 32'h0);
    step();
    rst = 1'b0;
    d0_idle_inputs();
    #1;
    chk("rstmid.mem_read",  32'(d0_mread), 32'h0);
    chk("rstmid.mem_addr",  d0_maddr,      32'h0);
    chk("rstmid.late_resp", 32'(d0_resp),  32'h0);
    step();
    d0_mresp = 1'b0;
    chk("rstmid.still_idle", 32'(d0_mread), 32'h0);
    d0_wr = 2'b01; d0_a[0] = 32'h900; d0_w[0] = 32'h77; d0_m[0] = 4'h6;
    sb.push_back('{0, 1'b0, 1'b1, 32'h900, 32'h77, 4'h6});
    step();
    sb_pop_check("rstmid.regrant", e);
    d0_mresp = 1'b1;
    #1;
    chk("rstmid.regrant_resp", 32'(d0_resp), 32'h1);
    step();
    d0_mresp = 1'b0;
    d0_idle_inputs();
    step();

    // round-robin on dut1; last_grant was reset to 3 by the pulse above
    for (int v = 0; v < 11; v++) begin
      d1_rd = rr[v].mask;
      rr_q.push_back(rr[v].port);
      step();
      if (rr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rr%0d.q_empty: got no expected entry, expected one", v);
        p = 0;
      end else begin
        p = rr_q.pop_front();
      end
      chk($sformatf("rr%0d.mem_read", v), 32'(d1_mread), 32'h1);
      chk($sformatf("rr%0d.mem_addr", v), d1_maddr, 32'h1000 + 32'(p * 16));
      d1_mresp = 1'b1;
      rd_v = 32'hA000 + 32'(v);
      d1_mrdata = rd_v;
      #1;
      one = 4'b0001 << p;
      chk($sformatf("rr%0d.req_resp", v), 32'(d1_resp), 32'(one));
      chk($sformatf("rr%0d.req_rdata", v), d1_rdata, rd_v);
      step();
      d1_mresp = 1'b0;
      #1;
      chk($sformatf("rr%0d.gap", v), 32'(d1_mread), 32'h0);
    end
    d1_rd = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_PORTS, 2, requester count; legal range 2..8.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MODE, 0, arbitration mode: 0 = fixed priority with port 0 highest; 1 = round-robin.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  the block's single clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_read  in  NUM_PORTS  per-port read request.
- req_write  in  NUM_PORTS  per-port write request.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  per-port write data; same packing as req_addr.
- req_mbe  in  NUM_PORTS*(DATA_W/8)  per-port byte enables; same packing as req_addr.
- req_resp  out  NUM_PORTS  per-port one-cycle completion pulse.
- req_rdata  out  DATA_W  read data, broadcast to all ports.
- mem_read  out  1  downstream read request.
- mem_write  out  1  downstream write request.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_mbe  out  DATA_W/8  downstream byte enables.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_W  downstream read data.

Function
REQ-003 The block SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-004 A port SHALL count as requesting when req_read[i] | req_write[i] is high.
REQ-005 In IDLE with at least one port requesting, the FSM SHALL grant exactly one port, register that port's read, write, addr, wdata and mbe, and move to BUSY on the next edge.
REQ-006 In IDLE with no port requesting, the FSM SHALL stay in IDLE.
REQ-007 For MODE=0, the grant SHALL go to the lowest-indexed requesting port.
REQ-008 For MODE=1, the grant SHALL go to the first requesting port found searching upward from last_grant+1, modulo NUM_PORTS.
REQ-009 For MODE=1, last_grant SHALL update only when a grant is made.
REQ-010 If a granted port has both read and write high, the block SHALL issue a write only; mem_read SHALL stay 0.
REQ-011 Latency: a request sampled in IDLE at edge t SHALL appear on mem_read or mem_write, with mem_addr, mem_wdata and mem_mbe valid, in the cycle after edge t.
REQ-012 In BUSY, all mem_* outputs SHALL be driven from registers and held stable until mem_resp is sampled high.
REQ-013 In BUSY, changes on req_* inputs SHALL have no effect on mem_*.
REQ-014 In the BUSY cycle where mem_resp=1, the block SHALL combinationally drive req_resp[grant]=1 and keep every other req_resp bit at 0.
REQ-015 At the edge ending that cycle, the FSM SHALL return to IDLE, and mem_read and mem_write SHALL be 0 in the next cycle.
REQ-016 req_rdata SHALL equal mem_rdata at all times.
REQ-017 After each transaction the block SHALL spend exactly one IDLE cycle before the next grant.
- Requesters drop their request in the cycle after req_resp, so a completed request is never reissued.
- Back-to-back throughput is therefore one transaction per (memory latency + 2) cycles.
REQ-018 mem_resp sampled while in IDLE SHALL be ignored: no req_resp pulse and no state change.
REQ-019 The block SHALL hold at most one outstanding downstream transaction at any time.
REQ-020 A port request that goes low before it is granted SHALL simply be dropped; no error is flagged.

Reset
REQ-021 While rst=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-022 While rst=1 at a clock edge, mem_read and mem_write SHALL become 0, and mem_addr, mem_wdata and mem_mbe SHALL become 0.
REQ-023 While rst=1 at a clock edge, last_grant SHALL become NUM_PORTS-1, so port 0 wins the first round-robin grant.
REQ-024 Reset asserted during BUSY SHALL abandon the transaction with no req_resp pulse.
REQ-025 A mem_resp arriving after that reset SHALL be ignored, per REQ-018.
REQ-026 req_resp SHALL be all zeros in every cycle where rst=1.

Verification
REQ-027 The bench SHALL cover the following directed scenarios.
- Single read: MODE=0; port1 read addr 0x0000_1000; mem_resp after 3 cycles with mem_rdata 0xDEAD_BEEF.
  -> mem_read rises 1 cycle after the request, mem_addr=0x0000_1000, req_resp=2'b10 for exactly 1 cycle, req_rdata=0xDEAD_BEEF.
- Fixed-priority contention: MODE=0; ports 0 and 1 request in the same cycle.
  -> port 0 is served first; port 1 is served after one IDLE gap.
- Round-robin fairness: MODE=1, NUM_PORTS=4; all ports request continuously and reassert after each resp.
  -> grant order is 0,1,2,3,0.
- Write with byte enables: port0 write addr 0x40, wdata 0x1122_3344, mbe 4'b0011; port0 changes addr during BUSY.
  -> mem_write=1, mem_mbe=4'b0011, mem_addr stays 0x40 until mem_resp.
- Read/write conflict: port0 asserts read and write together.
  -> only mem_write is asserted.
- Reset mid-transaction: rst pulsed during BUSY, then mem_resp arrives.
  -> mem_read=0 the next cycle, no req_resp pulse, FSM is IDLE.
